// File: rtl/vector_alu_pkg.sv
// vector_alu_pkg: shared constants for the EX-stage vector ALU.
//   Function-code constants, lane-width (ww) encodings and a lane-count helper.
//   The optional divide/modulo/square-root datapath is enabled by the
//   VECTOR_ALU_DIVSQRT_EN macro (see vector_alu.sv).
package vector_alu_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned FC_W   = 6;
  localparam int unsigned WW_W   = 2;

  // Function codes
  localparam logic [FC_W-1:0] VAND   = 6'b000001;
  localparam logic [FC_W-1:0] VOR    = 6'b000010;
  localparam logic [FC_W-1:0] VXOR   = 6'b000011;
  localparam logic [FC_W-1:0] VNOT   = 6'b000100;
  localparam logic [FC_W-1:0] VMOV   = 6'b000101;
  localparam logic [FC_W-1:0] VADD   = 6'b000110;
  localparam logic [FC_W-1:0] VSUB   = 6'b000111;
  localparam logic [FC_W-1:0] VMULEU = 6'b001000;
  localparam logic [FC_W-1:0] VMULOU = 6'b001001;
  localparam logic [FC_W-1:0] VSLL   = 6'b001010;
  localparam logic [FC_W-1:0] VSRL   = 6'b001011;
  localparam logic [FC_W-1:0] VSRA   = 6'b001100;
  localparam logic [FC_W-1:0] VRTTH  = 6'b001101;
  localparam logic [FC_W-1:0] VDIV   = 6'b001110;
  localparam logic [FC_W-1:0] VMOD   = 6'b001111;
  localparam logic [FC_W-1:0] VSQEU  = 6'b010000;
  localparam logic [FC_W-1:0] VSQOU  = 6'b010001;
  localparam logic [FC_W-1:0] VSQRT  = 6'b010010;

  // Lane-width encodings
  localparam logic [WW_W-1:0] bMode = 2'b00;
  localparam logic [WW_W-1:0] hMode = 2'b01;
  localparam logic [WW_W-1:0] wMode = 2'b10;
  localparam logic [WW_W-1:0] dMode = 2'b11;

  // Number of lanes in a 64-bit operand for a given width encoding
  function automatic int unsigned lane_count(input logic [WW_W-1:0] ww);
    return 32'd8 >> ww;
  endfunction

endpackage

// File: rtl/vector_alu_if.sv
// vector_alu_if: operand/result bundle between the EX stage and the vector ALU.
//   rAex, rBex      operands (bit 0 = MSB, lane 0 = most significant lane)
//   functionCodeEX  operation select
//   wwEX            lane width
//   rDex            registered result
//   master drives operands and reads the result; slave is the ALU.
interface vector_alu_if;
  import vector_alu_pkg::*;

  logic [0:DATA_W-1] rAex;
  logic [0:DATA_W-1] rBex;
  logic [0:FC_W-1]   functionCodeEX;
  logic [0:WW_W-1]   wwEX;
  logic [0:DATA_W-1] rDex;

  modport master (output rAex, rBex, functionCodeEX, wwEX, input rDex);
  modport slave  (input rAex, rBex, functionCodeEX, wwEX, output rDex);
endinterface

// File: rtl/vector_alu_sqrt.sv
// vector_alu_sqrt: combinational floor(sqrt(x)) of one unsigned 64-bit value.
//   x_i     64-bit radicand
//   root_o  32-bit floor square root
// Restoring digit-by-digit method, two radicand bits per step.
module vector_alu_sqrt (
  input  logic [63:0] x_i,
  output logic [31:0] root_o
);

  always_comb begin
    logic [35:0] rem;
    logic [35:0] trial;
    logic [31:0] root;
    rem   = '0;
    trial = '0;
    root  = '0;
    for (int i = 31; i >= 0; i--) begin
      rem   = {rem[33:0], x_i[6'(2 * i) +: 2]};
      trial = {2'b00, root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[30:0], 1'b1};
      end else begin
        root = {root[30:0], 1'b0};
      end
    end
    root_o = root;
  end

endmodule

// File: rtl/vector_alu.sv
// vector_alu: EX-stage packed-lane vector ALU with a one-cycle registered result.
//   clk    clock
//   reset  synchronous active-high clear of the result register
//   bus    vector_alu_if.slave (rAex, rBex, functionCodeEX, wwEX in; rDex out)
// Define VECTOR_ALU_DIVSQRT_EN to build VDIV/VMOD/VSQRT; otherwise they return 0.
module vector_alu
  import vector_alu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  vector_alu_if.slave  bus
);

  logic [63:0] a, b, rd_d, rd_q, lane_mux, mul_mux, sqrt_res;
  logic [5:0]  fc;
  logic [1:0]  ww;
  logic        odd_sel, sq_sel;

  // Re-index [0:63] big-endian buses into descending vectors (MSB kept on the left)
  assign a  = bus.rAex;
  assign b  = bus.rBex;
  assign fc = bus.functionCodeEX;
  assign ww = bus.wwEX;

  assign odd_sel = (fc == VMULOU) || (fc == VSQOU);
  assign sq_sel  = (fc == VSQEU)  || (fc == VSQOU);

  // Per-width lane-wise ops; lane i sits at bits [63-i*W -: W]
  for (genvar g = 0; g < 4; g++) begin : g_lane
    localparam int unsigned W  = 8 << g;
    localparam int unsigned N  = 64 / W;
    localparam int unsigned SH = 3 + g;
    logic [63:0] res;

    always_comb begin
      logic [W-1:0]  a_l, b_l, r_l;
      logic [SH-1:0] sh;
      logic [5:0]    lsb;
      res = '0;
      a_l = '0;
      b_l = '0;
      r_l = '0;
      sh  = '0;
      lsb = '0;
      for (int i = 0; i < N; i++) begin
        lsb = 6'(64 - (i + 1) * W);
        a_l = a[lsb +: W];
        b_l = b[lsb +: W];
        sh  = b_l[SH-1:0];
        case (fc)
          VADD:  r_l = a_l + b_l;
          VSUB:  r_l = a_l - b_l;
          VSLL:  r_l = a_l << sh;
          VSRL:  r_l = a_l >> sh;
          VSRA:  r_l = $signed(a_l) >>> sh;
          VRTTH: r_l = {a_l[W/2-1:0], a_l[W-1:W/2]};
`ifdef VECTOR_ALU_DIVSQRT_EN
          VDIV:  r_l = (b_l == '0) ? '0 : a_l / b_l;
          VMOD:  r_l = (b_l == '0) ? '0 : a_l % b_l;
`endif
          default: r_l = '0;
        endcase
        res[lsb +: W] = r_l;
      end
    end
  end

  // Widening multiply/square: pair p covers lanes 2p (upper) and 2p+1 (lower)
  for (genvar g = 0; g < 3; g++) begin : g_mul
    localparam int unsigned W  = 8 << g;
    localparam int unsigned W2 = 2 * W;
    localparam int unsigned NP = 32 / W;
    logic [63:0] res;

    always_comb begin
      logic [W-1:0] ea, eb;
      logic [5:0]   lo, hi;
      res = '0;
      ea  = '0;
      eb  = '0;
      lo  = '0;
      hi  = '0;
      for (int p = 0; p < NP; p++) begin
        lo = 6'(64 - (p + 1) * W2);
        hi = 6'(64 - (p + 1) * W2 + W);
        ea = odd_sel ? a[lo +: W] : a[hi +: W];
        eb = sq_sel ? ea : (odd_sel ? b[lo +: W] : b[hi +: W]);
        res[lo +: W2] = W2'(ea) * W2'(eb);
      end
    end
  end

  // Width select for lane-wise and widening results (no doubleword widening)
  always_comb begin
    lane_mux = '0;
    mul_mux  = '0;
    case (ww)
      bMode:   begin lane_mux = g_lane[0].res; mul_mux = g_mul[0].res; end
      hMode:   begin lane_mux = g_lane[1].res; mul_mux = g_mul[1].res; end
      wMode:   begin lane_mux = g_lane[2].res; mul_mux = g_mul[2].res; end
      default: begin lane_mux = g_lane[3].res; mul_mux = '0;           end
    endcase
  end

`ifdef VECTOR_ALU_DIVSQRT_EN
  // Eight shared root units; slot k takes lane k at the current width, zero-extended
  logic [63:0] sq_in  [8];
  logic [31:0] sq_out [8];

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      sq_in[k] = '0;
      if (32'(k) < lane_count(ww)) begin
        case (ww)
          bMode:   sq_in[k] = 64'(a[6'(56 - 8 * k) +: 8]);
          hMode:   sq_in[k] = 64'(a[6'(48 - 16 * k) +: 16]);
          wMode:   sq_in[k] = 64'(a[6'(32 - 32 * k) +: 32]);
          default: sq_in[k] = a;
        endcase
      end
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_sqrt
    vector_alu_sqrt u_sqrt (
      .x_i    (sq_in[k]),
      .root_o (sq_out[k])
    );
  end

  // Root of a W-bit lane fits in W/2 bits, so the upper half of each lane stays 0
  always_comb begin
    sqrt_res = '0;
    for (int k = 0; k < 8; k++) begin
      case (ww)
        bMode:   sqrt_res[6'(56 - 8 * k) +: 8] = sq_out[k][7:0];
        hMode:   if (k < 4) sqrt_res[6'(48 - 16 * k) +: 16] = sq_out[k][15:0];
        wMode:   if (k < 2) sqrt_res[6'(32 - 32 * k) +: 32] = sq_out[k];
        default: if (k == 0) sqrt_res = 64'(sq_out[0]);
      endcase
    end
  end
`else
  assign sqrt_res = '0;
`endif

  // Final operation select
  always_comb begin
    rd_d = '0;
    case (fc)
      VAND: rd_d = a & b;
      VOR:  rd_d = a | b;
      VXOR: rd_d = a ^ b;
      VNOT: rd_d = ~a;
      VMOV: rd_d = a;
      VADD, VSUB, VSLL, VSRL, VSRA, VRTTH: rd_d = lane_mux;
      VMULEU, VMULOU, VSQEU, VSQOU:        rd_d = mul_mux;
`ifdef VECTOR_ALU_DIVSQRT_EN
      VDIV, VMOD: rd_d = lane_mux;
      VSQRT:      rd_d = sqrt_res;
`endif
      default: rd_d = '0;
    endcase
  end

  // Result register
  always_ff @(posedge clk) begin
    if (reset) rd_q <= '0;
    else       rd_q <= rd_d;
  end

  assign bus.rDex = rd_q;

endmodule

// File: tb/tb_vector_alu.sv
// tb_vector_alu: directed self-checking bench for vector_alu.
module tb_vector_alu;
  import vector_alu_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic [63:0] exp_v;

  vector_alu_if alu_if ();

  vector_alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (alu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation for one cycle; return 1 ns after the capturing edge
  task automatic run_op(input logic [5:0] fc, input logic [1:0] ww,
                        input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    alu_if.functionCodeEX = fc;
    alu_if.wwEX           = ww;
    alu_if.rAex           = a;
    alu_if.rBex           = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run_op(VMOV, bMode, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    run_op(VMOV, bMode, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    n_cmp++;
    if (alu_if.rDex !== 64'h0) begin
      n_err++; $display("FAIL reset_hold got %h exp %h", alu_if.rDex, 64'h0);
    end
    reset = 1'b0;
    run_op(VMOV, bMode, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    n_cmp++;
    if (alu_if.rDex !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_err++; $display("FAIL reset_release got %h exp %h", alu_if.rDex, 64'hFFFF_FFFF_FFFF_FFFF);
    end
  endtask

  task automatic test_logic();
    logic [63:0] a, b;
    a = 64'hF0F0_F0F0_0F0F_FF00;
    b = 64'hFF00_FF00_FF00_FF00;
    run_op(VAND, hMode, a, b); n_cmp++;
    if (alu_if.rDex !== 64'hF000_F000_0F00_FF00) begin
      n_err++; $display("FAIL vand got %h exp %h", alu_if.rDex, 64'hF000_F000_0F00_FF00);
    end
    run_op(VOR, wMode, a, b); n_cmp++;
    if (alu_if.rDex !== 64'hFFF0_FFF0_FF0F_FF00) begin
      n_err++; $display("FAIL vor got %h exp %h", alu_if.rDex, 64'hFFF0_FFF0_FF0F_FF00);
    end
    run_op(VXOR, dMode, a, b); n_cmp++;
    if (alu_if.rDex !== 64'h0FF0_0FF0_F00F_0000) begin
      n_err++; $display("FAIL vxor got %h exp %h", alu_if.rDex, 64'h0FF0_0FF0_F00F_0000);
    end
    run_op(VNOT, bMode, a, b); n_cmp++;
    if (alu_if.rDex !== 64'h0F0F_0F0F_F0F0_00FF) begin
      n_err++; $display("FAIL vnot got %h exp %h", alu_if.rDex, 64'h0F0F_0F0F_F0F0_00FF);
    end
  endtask

  task automatic test_addsub();
    run_op(VADD, bMode, 64'h0000_0000_0000_00FF, 64'h1); n_cmp++;
    if (alu_if.rDex !== 64'h0) begin
      n_err++; $display("FAIL vadd_b got %h exp %h", alu_if.rDex, 64'h0);
    end
    run_op(VADD, dMode, 64'h0000_0000_0000_00FF, 64'h1); n_cmp++;
    if (alu_if.rDex !== 64'h100) begin
      n_err++; $display("FAIL vadd_d got %h exp %h", alu_if.rDex, 64'h100);
    end
    run_op(VSUB, bMode, 64'h0, 64'h1); n_cmp++;
    if (alu_if.rDex !== 64'hFF) begin
      n_err++; $display("FAIL vsub_b got %h exp %h", alu_if.rDex, 64'hFF);
    end
    run_op(VSUB, dMode, 64'h0, 64'h1); n_cmp++;
    if (alu_if.rDex !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_err++; $display("FAIL vsub_d got %h exp %h", alu_if.rDex, 64'hFFFF_FFFF_FFFF_FFFF);
    end
  endtask

  task automatic test_mul();
    run_op(VMULEU, hMode, 64'hFFFF_0000_0002_0000, 64'hFFFF_0000_0003_0000); n_cmp++;
    if (alu_if.rDex !== 64'hFFFE_0001_0000_0006) begin
      n_err++; $display("FAIL vmuleu_h got %h exp %h", alu_if.rDex, 64'hFFFE_0001_0000_0006);
    end
    run_op(VMULOU, bMode, 64'h0102_0304_0506_0708, 64'h0A0B_0C0D_0E0F_1011); n_cmp++;
    if (alu_if.rDex !== 64'h0016_0034_005A_0088) begin
      n_err++; $display("FAIL vmulou_b got %h exp %h", alu_if.rDex, 64'h0016_0034_005A_0088);
    end
    run_op(VMULEU, dMode, 64'h5, 64'h7); n_cmp++;
    if (alu_if.rDex !== 64'h0) begin
      n_err++; $display("FAIL vmuleu_d got %h exp %h", alu_if.rDex, 64'h0);
    end
    run_op(VSQEU, wMode, 64'h0000_FFFF_0001_0000, 64'h0); n_cmp++;
    if (alu_if.rDex !== 64'h0000_0000_FFFE_0001) begin
      n_err++; $display("FAIL vsqeu_w got %h exp %h", alu_if.rDex, 64'h0000_0000_FFFE_0001);
    end
    run_op(VSQOU, wMode, 64'h0000_FFFF_0001_0000, 64'h0); n_cmp++;
    if (alu_if.rDex !== 64'h0000_0001_0000_0000) begin
      n_err++; $display("FAIL vsqou_w got %h exp %h", alu_if.rDex, 64'h0000_0001_0000_0000);
    end
    run_op(VSQOU, dMode, 64'h3, 64'h0); n_cmp++;
    if (alu_if.rDex !== 64'h0) begin
      n_err++; $display("FAIL vsqou_d got %h exp %h", alu_if.rDex, 64'h0);
    end
  endtask

  task automatic test_shift_rot();
    run_op(VSRA, wMode, 64'h8000_0000_0000_0010, 64'h0000_0004_0000_0024); n_cmp++;
    if (alu_if.rDex !== 64'hF800_0000_0000_0001) begin
      n_err++; $display("FAIL vsra_w got %h exp %h", alu_if.rDex, 64'hF800_0000_0000_0001);
    end
    run_op(VSLL, bMode, 64'h8101_0101_0101_0101, 64'h0102_0304_0506_0708); n_cmp++;
    if (alu_if.rDex !== 64'h0204_0810_2040_8001) begin
      n_err++; $display("FAIL vsll_b got %h exp %h", alu_if.rDex, 64'h0204_0810_2040_8001);
    end
    run_op(VSRL, hMode, 64'h8000_8000_8000_FFFF, 64'h0001_000F_0010_0004); n_cmp++;
    if (alu_if.rDex !== 64'h4000_0001_8000_0FFF) begin
      n_err++; $display("FAIL vsrl_h got %h exp %h", alu_if.rDex, 64'h4000_0001_8000_0FFF);
    end
    run_op(VRTTH, bMode, 64'h1234_5678_9ABC_DEF0, 64'h0); n_cmp++;
    if (alu_if.rDex !== 64'h2143_6587_A9CB_ED0F) begin
      n_err++; $display("FAIL vrtth_b got %h exp %h", alu_if.rDex, 64'h2143_6587_A9CB_ED0F);
    end
    run_op(VRTTH, dMode, 64'h0123_4567_89AB_CDEF, 64'h0); n_cmp++;
    if (alu_if.rDex !== 64'h89AB_CDEF_0123_4567) begin
      n_err++; $display("FAIL vrtth_d got %h exp %h", alu_if.rDex, 64'h89AB_CDEF_0123_4567);
    end
  endtask

  task automatic test_divsqrt();
    logic [63:0] e_div, e_mod, e_sqrt;
`ifdef VECTOR_ALU_DIVSQRT_EN
    e_div  = 64'h000E_0000_0FFF_0005;
    e_mod  = 64'h0002_0000_000F_0001;
    e_sqrt = 64'h0000_000A_0000_FFFF;
`else
    e_div  = 64'h0;
    e_mod  = 64'h0;
    e_sqrt = 64'h0;
`endif
    run_op(VDIV, hMode, 64'h0064_0007_FFFF_0010, 64'h0007_0000_0010_0003); n_cmp++;
    if (alu_if.rDex !== e_div) begin
      n_err++; $display("FAIL vdiv_h got %h exp %h", alu_if.rDex, e_div);
    end
    run_op(VMOD, hMode, 64'h0064_0007_FFFF_0010, 64'h0007_0000_0010_0003); n_cmp++;
    if (alu_if.rDex !== e_mod) begin
      n_err++; $display("FAIL vmod_h got %h exp %h", alu_if.rDex, e_mod);
    end
    run_op(VSQRT, wMode, 64'h0000_0064_FFFF_FFFF, 64'h0); n_cmp++;
    if (alu_if.rDex !== e_sqrt) begin
      n_err++; $display("FAIL vsqrt_w got %h exp %h", alu_if.rDex, e_sqrt);
    end
  endtask

  task automatic test_invalid();
    run_op(6'b111111, bMode, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF); n_cmp++;
    if (alu_if.rDex !== 64'h0) begin
      n_err++; $display("FAIL invalid_3f got %h exp %h", alu_if.rDex, 64'h0);
    end
    run_op(6'b000000, dMode, 64'h1234, 64'h5678); n_cmp++;
    if (alu_if.rDex !== 64'h0) begin
      n_err++; $display("FAIL invalid_00 got %h exp %h", alu_if.rDex, 64'h0);
    end
  endtask

  // One op per cycle, each result visible exactly one edge later, then a mid-stream reset
  task automatic test_back_to_back();
    run_op(VMOV, bMode, 64'hDEAD_BEEF_0000_0001, 64'h0); n_cmp++;
    if (alu_if.rDex !== 64'hDEAD_BEEF_0000_0001) begin
      n_err++; $display("FAIL b2b_0 got %h exp %h", alu_if.rDex, 64'hDEAD_BEEF_0000_0001);
    end
    run_op(VADD, hMode, 64'hFFFF_0001_7FFF_1234, 64'h0001_0001_0001_1111); n_cmp++;
    exp_v = 64'h0000_0002_8000_2345;
    if (alu_if.rDex !== exp_v) begin
      n_err++; $display("FAIL b2b_1 got %h exp %h", alu_if.rDex, exp_v);
    end
    reset = 1'b1;
    run_op(VMOV, dMode, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0); n_cmp++;
    if (alu_if.rDex !== 64'h0) begin
      n_err++; $display("FAIL b2b_reset got %h exp %h", alu_if.rDex, 64'h0);
    end
    reset = 1'b0;
    run_op(VXOR, wMode, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_0000_0000); n_cmp++;
    if (alu_if.rDex !== 64'h5555_5555_AAAA_AAAA) begin
      n_err++; $display("FAIL b2b_2 got %h exp %h", alu_if.rDex, 64'h5555_5555_AAAA_AAAA);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    alu_if.functionCodeEX = '0;
    alu_if.wwEX           = '0;
    alu_if.rAex           = '0;
    alu_if.rBex           = '0;
    test_reset();
    test_logic();
    test_addsub();
    test_mul();
    test_shift_rot();
    test_divsqrt();
    test_invalid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
